// File: rtl/i2s_tx.sv
// i2s_tx: mono 24-bit I2S transmitter; SCLK = clk_i / (2*SCLK_HALF), 64 slots per frame.
// Define I2S_TX_OVERRUN_EN to build the sticky overrun flag; otherwise overrun_o is tied low.
module i2s_tx #(
    parameter int SCLK_HALF = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic signed [23:0] sample_i,
    input  logic               sample_valid_i,
    output logic               sclk_o,
    output logic               lrck_o,
    output logic               sdata_o,
    output logic               frame_o,
    output logic               underrun_o,
    output logic               overrun_o
);
    localparam int DATA_W = 24;
    localparam int DIV_W  = $clog2(SCLK_HALF);

    logic [DIV_W-1:0]         div_q, div_d;
    logic                     sclk_q, sclk_d;
    logic [5:0]               slot_q, slot_d;
    logic                     lrck_q, lrck_d;
    logic                     sdata_q, sdata_d;
    logic                     frame_q, frame_d;
    logic                     underrun_q, underrun_d;
    logic signed [DATA_W-1:0] hold_q, hold_d;
    logic                     pend_q, pend_d;
    logic signed [DATA_W-1:0] word_q, word_d;
    logic                     div_wrap;
    logic                     fall;
    logic                     load;

    // Slot 0 is the one-bit I2S delay; slots 1..24 carry the word MSB first, the rest are zero.
    function automatic logic slot_bit(input logic signed [DATA_W-1:0] word,
                                      input logic [4:0] slot);
        logic [DATA_W-1:0] sh;
        sh = '0;
        if (slot >= 5'd1 && slot <= 5'd24) begin
            sh = DATA_W'(word) << (slot - 5'd1);
        end
        return sh[DATA_W-1];
    endfunction

    always_comb begin
        div_wrap   = (div_q == DIV_W'(SCLK_HALF - 1));
        fall       = div_wrap && sclk_q;
        load       = fall && (slot_q == 6'd63);

        div_d      = div_wrap ? '0 : div_q + DIV_W'(1);
        sclk_d     = div_wrap ? ~sclk_q : sclk_q;
        slot_d     = slot_q;
        lrck_d     = lrck_q;
        sdata_d    = sdata_q;
        hold_d     = hold_q;
        pend_d     = pend_q;
        word_d     = word_q;
        frame_d    = load;
        underrun_d = 1'b0;

        if (fall) begin
            slot_d  = slot_q + 6'd1;
            lrck_d  = slot_d[5];
            sdata_d = slot_bit(word_q, slot_d[4:0]);
        end

        // A strobe landing on the load cycle bypasses the holding register entirely.
        if (load) begin
            if (sample_valid_i) begin
                word_d = sample_i;
                pend_d = 1'b0;
            end else if (pend_q) begin
                word_d = hold_q;
                pend_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end else if (sample_valid_i) begin
            hold_d = sample_i;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q      <= '0;
            sclk_q     <= 1'b0;
            slot_q     <= '0;
            lrck_q     <= 1'b0;
            sdata_q    <= 1'b0;
            frame_q    <= 1'b0;
            underrun_q <= 1'b0;
            hold_q     <= '0;
            pend_q     <= 1'b0;
            word_q     <= '0;
        end else begin
            div_q      <= div_d;
            sclk_q     <= sclk_d;
            slot_q     <= slot_d;
            lrck_q     <= lrck_d;
            sdata_q    <= sdata_d;
            frame_q    <= frame_d;
            underrun_q <= underrun_d;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
            word_q     <= word_d;
        end
    end

`ifdef I2S_TX_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (sample_valid_i && !load && pend_q) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_o = overrun_q;
`else
    assign overrun_o = 1'b0;
`endif

    assign sclk_o     = sclk_q;
    assign lrck_o     = lrck_q;
    assign sdata_o    = sdata_q;
    assign frame_o    = frame_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: stimulus pushes expected frames, a monitor deserialises and compares.
module tb_i2s_tx;
    localparam int SCLK_HALF = 4;
    localparam int FRAME     = 128 * SCLK_HALF;
    localparam int MAXE      = 8192;

    logic               clk = 1'b0;
    logic               reset_i = 1'b1;
    logic signed [23:0] sample_i = '0;
    logic               sample_valid_i = 1'b0;
    logic               sclk_o, lrck_o, sdata_o, frame_o, underrun_o, overrun_o;

    always #5 clk = ~clk;

    i2s_tx #(.SCLK_HALF(SCLK_HALF)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .sample_i      (sample_i),
        .sample_valid_i(sample_valid_i),
        .sclk_o        (sclk_o),
        .lrck_o        (lrck_o),
        .sdata_o       (sdata_o),
        .frame_o       (frame_o),
        .underrun_o    (underrun_o),
        .overrun_o     (overrun_o)
    );

    int          total = 0;
    int          bad   = 0;
    logic [24:0] exp_q[$];
    logic        vmap[0:MAXE];
    logic [23:0] smap[0:MAXE];

    logic        m_pend, m_ovr;
    logic [23:0] m_hold, m_word;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic exp_ovr();
`ifdef I2S_TX_OVERRUN_EN
        return m_ovr;
`else
        return 1'b0;
`endif
    endfunction

    task automatic clear_maps();
        for (int i = 0; i <= MAXE; i++) begin
            vmap[i] = 1'b0;
            smap[i] = '0;
        end
    endtask

    // Monitor: pops one expectation per frame_o and collects 64 slots on sclk rising edges.
    logic        cap = 1'b0, seen = 1'b0, pre_any = 1'b0, sclk_prev = 1'b0;
    int          nbit = 0;
    int          stray = 0;
    logic [63:0] got_d, got_l, exp_d;
    logic [24:0] e;

    always @(negedge clk) begin
        if (reset_i) begin
            cap = 1'b0; seen = 1'b0; pre_any = 1'b0; sclk_prev = 1'b0;
        end else begin
            if (underrun_o && !frame_o) stray++;
            if (frame_o) begin
                if (!seen) check("pre_frame_sdata_zero", 64'(pre_any), 64'd0);
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    check("frame_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("underrun_at_frame", 64'(underrun_o), 64'(e[24]));
                    exp_d = {1'b0, e[23:0], 7'b0, 1'b0, e[23:0], 7'b0};
                    cap = 1'b1; nbit = 0; got_d = '0; got_l = '0;
                end
            end
            if (sclk_o && !sclk_prev) begin
                if (!seen) pre_any = pre_any | sdata_o;
                if (cap) begin
                    got_d = {got_d[62:0], sdata_o};
                    got_l = {got_l[62:0], lrck_o};
                    nbit++;
                    if (nbit == 64) begin
                        check("frame_sdata", got_d, exp_d);
                        check("frame_lrck", got_l, {32'h0, 32'hFFFF_FFFF});
                        cap = 1'b0;
                    end
                end
            end
            sclk_prev = sclk_o;
        end
    end

    // Edge n counts clk rises since reset release; frame loads happen on every multiple of FRAME.
    task automatic run_session(input int nedges, input int sess);
        logic und;
        m_pend = 1'b0; m_hold = '0; m_word = '0;
        for (int n = 1; n <= nedges; n++) begin
            sample_valid_i = vmap[n];
            sample_i       = smap[n];
            if (n % FRAME == 0) begin
                und = 1'b0;
                if (vmap[n]) begin
                    m_word = smap[n]; m_pend = 1'b0;
                end else if (m_pend) begin
                    m_word = m_hold; m_pend = 1'b0;
                end else begin
                    und = 1'b1;
                end
                exp_q.push_back({und, m_word});
            end else if (vmap[n]) begin
                if (m_pend) m_ovr = 1'b1;
                m_hold = smap[n];
                m_pend = 1'b1;
            end
            @(posedge clk); #1;
            sample_valid_i = 1'b0;
            if (n == SCLK_HALF - 1) check("sclk_before_first_rise", 64'(sclk_o), 64'd0);
            if (n == SCLK_HALF)     check("sclk_first_rise", 64'(sclk_o), 64'd1);
            if (sess == 1 && n == 2400) check("overrun_after_double", 64'(overrun_o), 64'(exp_ovr()));
        end
    endtask

    initial begin
        int k;
        int t;
        clear_maps();
        m_ovr = 1'b0;
        reset_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({sclk_o, lrck_o, sdata_o, frame_o, underrun_o, overrun_o}), 64'd0);

        vmap[700]  = 1'b1; smap[700]  = 24'hA5A5A5;
        vmap[1536] = 1'b1; smap[1536] = 24'h800000;
        vmap[2100] = 1'b1; smap[2100] = 24'h000001;
        vmap[2300] = 1'b1; smap[2300] = 24'h7FFFFF;
        for (int f = 6; f <= 14; f++) begin
            k = int'($urandom_range(0, 3));
            for (int j = 0; j < k; j++) begin
                t = FRAME * (f - 1) + int'($urandom_range(1, FRAME));
                vmap[t] = 1'b1;
                smap[t] = 24'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                vmap[FRAME * f] = 1'b1;
                smap[FRAME * f] = 24'($urandom);
            end
        end
        vmap[FRAME * 14 + 100] = 1'b1;
        smap[FRAME * 14 + 100] = 24'hFFFFFF;

        reset_i = 1'b0;
        run_session(FRAME * 14 + 322, 1);
        check("overrun_end_session1", 64'(overrun_o), 64'(exp_ovr()));

        // One-cycle reset in slot 40 with a sample pending.
        reset_i = 1'b1;
        exp_q.delete();
        m_ovr = 1'b0;
        @(posedge clk); #1;
        check("reset_mid_frame_outputs",
              64'({sclk_o, lrck_o, sdata_o, frame_o, underrun_o, overrun_o}), 64'd0);
        reset_i = 1'b0;

        clear_maps();
        vmap[700] = 1'b1;
        smap[700] = 24'($urandom);
        run_session(FRAME * 4 - 2, 2);
        check("overrun_end_session2", 64'(overrun_o), 64'(exp_ovr()));
        check("stray_underrun", 64'(stray), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
- REQ-001 SHALL have parameter SCLK_HALF, default 4: clk_i cycles per SCLK half-period; legal values are 2 or more.
- REQ-002 SHALL have port clk_i, input, 1 bit: single system clock, which is also MCLK.
- REQ-003 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
- REQ-004 SHALL have port sample_i, input, 24 bits: signed audio sample, two's complement.
- REQ-005 SHALL have port sample_valid_i, input, 1 bit: one-cycle strobe qualifying sample_i; there is no backpressure.
- REQ-006 SHALL have port sclk_o, output, 1 bit: I2S bit clock.
- REQ-007 SHALL have port lrck_o, output, 1 bit: word select; 0 = left, 1 = right.
- REQ-008 SHALL have port sdata_o, output, 1 bit: serial data, MSB first.
- REQ-009 SHALL have port frame_o, output, 1 bit: one-cycle pulse when a new frame word is loaded.
- REQ-010 SHALL have port underrun_o, output, 1 bit: one-cycle pulse when a frame loads with no new sample pending.
- REQ-011 SHALL have port overrun_o, output, 1 bit: overrun status (see Configuration).

Function
- REQ-012 SHALL run a divider counter from 0 to SCLK_HALF-1 and toggle sclk_o on each wrap, so the SCLK period is 2*SCLK_HALF clk_i cycles.
- REQ-013 SHALL advance a 6-bit slot counter modulo 64 in the clk_i cycle in which sclk_o falls; lrck_o SHALL equal slot counter bit 5.
- REQ-014 SHALL change sdata_o and lrck_o only on sclk_o falling edges, registered in the same cycle as the toggle, so the receiver samples on rising edges.
- REQ-015 Within each 32-slot half-frame, slot 0 SHALL carry 0, slots 1..24 SHALL carry word bits 23..0, and slots 25..31 SHALL carry 0; this is the standard I2S one-bit delay.
- REQ-016 The sample is mono: the same 24-bit word SHALL be sent in the left and right halves of a frame.
- REQ-017 SHALL hold a single-entry holding register with a pending flag; sample_valid_i loads the register and sets the flag.
- REQ-018 Frame load SHALL occur on the falling edge where the slot counter wraps 63 to 0: the frame word is copied from the holding register, the pending flag clears, and frame_o pulses in that cycle.
- REQ-019 If the pending flag is clear at frame load, the previous frame word SHALL be repeated and underrun_o SHALL pulse.
- REQ-020 If sample_valid_i coincides with the frame-load cycle, sample_i SHALL be loaded directly into the frame word, the pending flag SHALL stay clear, and no underrun SHALL be flagged.
- REQ-021 If sample_valid_i arrives while the flag is pending and it is not a load cycle, the new sample SHALL overwrite the holding register (latest wins) and an overrun event SHALL be raised.
- REQ-022 The frame word SHALL remain stable for all 64 slots; the holding register may change during a frame without affecting sdata_o.

Reset
- REQ-023 While reset_i is high at a clk_i edge, the following SHALL be cleared to 0: sclk_o, lrck_o, sdata_o, frame_o, underrun_o, overrun_o, the divider, the slot counter, the holding register, the pending flag and the frame word.
- REQ-024 Reset asserted mid-frame SHALL abort serialization immediately, and any pending sample SHALL be discarded.
- REQ-025 After reset release, the first sclk_o rise SHALL occur SCLK_HALF cycles later; the first frame transmits zeros.

Configuration
- REQ-026 With macro I2S_TX_OVERRUN_EN defined, overrun_o SHALL be sticky: it is set by an overrun event and cleared only by reset_i.
- REQ-027 Without I2S_TX_OVERRUN_EN, overrun_o SHALL be tied to 0 and no overrun logic is built; the overwrite behaviour of REQ-021 is unchanged.

Verification (SCLK_HALF=4: SCLK period 8 clk, frame 512 clk)
- REQ-028 Reset release, no samples -> sclk_o first rises at cycle 4; lrck_o toggles every 256 cycles; sdata_o stays 0; frame_o fires every 512 cycles; underrun_o pulses with each frame_o.
- REQ-029 sample_i=24'h A5A5A5 with valid mid-frame -> at the next frame both halves carry slot 0 = 0, slots 1..24 = A5A5A5 MSB first, slots 25..31 = 0; no underrun.
- REQ-030 Valid coinciding with the frame-load cycle, sample_i=24'h800000 -> that frame carries 800000 (slot 1 = 1, slots 2..24 = 0); the pending flag is clear; no underrun on the following frame only if another sample arrives.
- REQ-031 Two valids, 24'h000001 then 24'h7FFFFF, within one frame -> the next frame sends 7FFFFF; overrun_o is 1 and stays 1 with the macro defined, 0 without it.
- REQ-032 reset_i pulsed high for 1 cycle at slot 40 with a sample pending -> all outputs are 0 the next cycle, timing restarts as in REQ-028, and the pending sample is never transmitted.
